dds_reload_ctrl: RTL and testbench
==================================

Name: dds_reload_ctrl

Overview:
- Sequences coefficient reloads from the coefficient table into the recursive oscillator whenever the rotary encoder changes frequency or the sampling controller changes mode.
- Sits between Rotary/SamplingCtrl, Table_coef and Oscillator, all in the Fg_clk domain.
- Fetches the table pair for the new address and waits for an oscillator phase boundary. It then issues a single-cycle load and waits for the oscillator's ready, so reloads never occur mid-cycle.
- Coalesces bursts of encoder events.

Parameters:
ADDR_W, 11, table address width
COEF_W, 32, coefficient width
TBL_LAT, 2, table read latency in cycles (>=1)
SYNC_TO, 4096, max cycles to wait for osc_wrap or osc_ready before forcing progress

Ports:
Fg_clk  in  1  system clock
Resetn  in  1  asynchronous active-low reset
FreqChng  in  1  one-cycle pulse, new address valid
ModeChng  in  1  one-cycle pulse, mode changed; reload current address
address  in  ADDR_W  requested table address (sampled on FreqChng/ModeChng)
tbl_addr  out  ADDR_W  address driven to Table_coef
tbl_sine1x  in  COEF_W  table output 1
tbl_cos2x  in  COEF_W  table output 2
osc_wrap  in  1  oscillator phase-boundary pulse
osc_ready  in  1  oscillator has accepted the load
init1  out  COEF_W  registered coefficient 1 to oscillator
init2  out  COEF_W  registered coefficient 2 to oscillator
osc_load  out  1  one-cycle load strobe
busy  out  1  high in any state other than IDLE
timeout  out  1  sticky; set on any SYNC_TO expiry, cleared only by reset

Behaviour:
- Reset (async, Resetn=0): state IDLE; tbl_addr=0; init1=init2=0; osc_load=0; busy=0; timeout=0; pend=0; pend_addr=0; counter=0.
- Event: ev = FreqChng | ModeChng. Both asserted in the same cycle count as one event.
- IDLE:
  - ev at cycle N: tbl_addr<=address; counter cleared; state FETCH at N+1.
- FETCH:
  - Counter increments each cycle.
  - When counter==TBL_LAT-1, capture tbl_sine1x/tbl_cos2x into init1/init2; state SYNC next cycle.
  - Coefficients are therefore captured TBL_LAT cycles after entering FETCH.
- SYNC:
  - Counter restarts at 0.
  - osc_wrap=1: go to LOAD next cycle.
  - Otherwise, counter==SYNC_TO-1: set timeout, go to LOAD.
- LOAD:
  - osc_load=1 for exactly this cycle; init1/init2 stable.
  - Next state ACK; counter cleared.
- ACK:
  - osc_ready=1, or counter==SYNC_TO-1 (sets timeout): leave ACK.
  - On exit with pend=1: tbl_addr<=pend_addr, pend<=0, go to FETCH. Otherwise go to IDLE.
- Coalescing:
  - ev while state!=IDLE: pend<=1, pend_addr<=address. The latest address wins and no event is queued beyond one.
  - ev in the ACK-exit cycle: FETCH uses the current address directly and pend ends 0.
- Hold rules:
  - init1/init2 change only at FETCH capture.
  - tbl_addr changes only on FETCH entry.
  - osc_load is never high in two consecutive cycles.
- osc_wrap outside SYNC and osc_ready outside ACK are ignored.
- Reset mid-operation: immediate return to reset values; the pending event is discarded.
- Width rules: counter is ceil(log2(max(TBL_LAT,SYNC_TO)))+1 bits. No arithmetic on coefficients; pure registers.
- Intended size: ~150-250 lines RTL; one FSM, one counter, pend register.

Test Plan:
- Basic reload:
  - Stimulus: FreqChng with address=100 in IDLE; table returns 0x1234_5678/0x0ABC_DEF0; osc_wrap 10 cycles later; osc_ready 1 cycle after load.
  - Required response: tbl_addr=100 next cycle; init1/init2 captured at FETCH+2; exactly one osc_load pulse; busy falls after ack; timeout=0.
- Burst coalescing:
  - Stimulus: FreqChng at address 5, then 6, 7, 8 during FETCH/SYNC.
  - Required response: exactly two osc_load pulses, for address 5 and then address 8; tbl_addr never equals 6 or 7.
- Sync timeout:
  - Stimulus: SYNC_TO=16 and osc_wrap held 0.
  - Required response: osc_load 16 cycles after SYNC entry; timeout=1 and stays 1 through a later clean reload.
- Ack timeout:
  - Stimulus: osc_ready held 0.
  - Required response: return to IDLE after SYNC_TO cycles in ACK; timeout=1; no second osc_load.
- Event in ACK-exit cycle:
  - Stimulus: ModeChng with address=42 in the same cycle osc_ready=1 while pend holds 30.
  - Required response: FETCH with tbl_addr=42; pend=0; one further load only.
- Reset mid-SYNC:
  - Stimulus: Resetn=0 for 100 ns while pend=1.
  - Required response: all outputs return to zero immediately; no osc_load after release until a new event.

Source files
------------

// File: rtl/dds_reload_ctrl.sv
// dds_reload_ctrl
// Sequences coefficient reloads from the coefficient table into the recursive
// oscillator. A reload is triggered by a frequency change (new address) or a
// mode change (reload current address). The controller fetches the table pair,
// waits for an oscillator phase boundary, issues a one-cycle load strobe and
// waits for the oscillator to acknowledge. Events arriving while a reload is
// in flight are coalesced into a single pending reload (latest address wins).
module dds_reload_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int COEF_W  = 32,
    parameter int TBL_LAT = 2,
    parameter int SYNC_TO = 4096
) (
    input  logic              Fg_clk,
    input  logic              Resetn,
    input  logic              FreqChng,
    input  logic              ModeChng,
    input  logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [COEF_W-1:0] tbl_sine1x,
    input  logic [COEF_W-1:0] tbl_cos2x,
    input  logic              osc_wrap,
    input  logic              osc_ready,
    output logic [COEF_W-1:0] init1,
    output logic [COEF_W-1:0] init2,
    output logic              osc_load,
    output logic              busy,
    output logic              timeout
);

    // One counter serves both the table-latency wait and the sync/ack watchdogs,
    // so it is sized for the larger of the two plus a guard bit.
    localparam int CNT_MAX = (TBL_LAT > SYNC_TO) ? TBL_LAT : SYNC_TO;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(TBL_LAT - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(SYNC_TO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SYNC  = 3'd2,
        LOAD  = 3'd3,
        ACK   = 3'd4
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                pend_reg;
    logic [ADDR_W-1:0]   pend_addr_reg;
    logic [ADDR_W-1:0]   tbl_addr_reg;
    logic [COEF_W-1:0]   init1_reg;
    logic [COEF_W-1:0]   init2_reg;
    logic                osc_load_reg;
    logic                timeout_reg;

    logic ev;
    logic ack_exit;

    // A simultaneous frequency and mode change is a single reload request.
    assign ev = FreqChng | ModeChng;

    // ACK is left either on the oscillator's acknowledge or on watchdog expiry.
    assign ack_exit = (state_reg == ACK) && (osc_ready || (cnt_reg == WAIT_LAST));

    // Reload sequencer: state, shared counter, pending-event slot and all outputs.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pend_reg      <= 1'b0;
            pend_addr_reg <= '0;
            tbl_addr_reg  <= '0;
            init1_reg     <= '0;
            init2_reg     <= '0;
            osc_load_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            // The strobe is raised only on the transition into LOAD, so it
            // can never last more than one cycle.
            osc_load_reg <= 1'b0;

            // Events during a reload collapse into one pending slot. An event in
            // the ACK exit cycle is consumed directly by the next fetch instead.
            if (ev && (state_reg != IDLE) && !ack_exit) begin
                pend_reg      <= 1'b1;
                pend_addr_reg <= address;
            end

            case (state_reg)
                IDLE: begin
                    if (ev) begin
                        tbl_addr_reg <= address;
                        cnt_reg      <= '0;
                        state_reg    <= FETCH;
                    end
                end

                FETCH: begin
                    if (cnt_reg == FETCH_LAST) begin
                        init1_reg <= tbl_sine1x;
                        init2_reg <= tbl_cos2x;
                        cnt_reg   <= '0;
                        state_reg <= SYNC;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                SYNC: begin
                    if (osc_wrap) begin
                        osc_load_reg <= 1'b1;
                        state_reg    <= LOAD;
                    end else if (cnt_reg == WAIT_LAST) begin
                        // No phase boundary seen: force the load and remember it.
                        timeout_reg  <= 1'b1;
                        osc_load_reg <= 1'b1;
                        state_reg    <= LOAD;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                LOAD: begin
                    cnt_reg   <= '0;
                    state_reg <= ACK;
                end

                ACK: begin
                    if (ack_exit) begin
                        if (!osc_ready) begin
                            timeout_reg <= 1'b1;
                        end
                        cnt_reg  <= '0;
                        pend_reg <= 1'b0;
                        if (ev) begin
                            tbl_addr_reg <= address;
                            state_reg    <= FETCH;
                        end else if (pend_reg) begin
                            tbl_addr_reg <= pend_addr_reg;
                            state_reg    <= FETCH;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tbl_addr = tbl_addr_reg;
    assign init1    = init1_reg;
    assign init2    = init2_reg;
    assign osc_load = osc_load_reg;
    assign timeout  = timeout_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_dds_reload_ctrl.sv
// Testbench for dds_reload_ctrl: table-driven basic reload, hand-written
// corner-case sequences and a randomized run against a countdown-based model.
module tb_dds_reload_ctrl;

    localparam int ADDR_W  = 11;
    localparam int COEF_W  = 32;
    localparam int TBL_LAT = 2;
    localparam int SYNC_TO = 16;

    logic              Fg_clk;
    logic              Resetn;
    logic              FreqChng;
    logic              ModeChng;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W-1:0] tbl_addr;
    logic [COEF_W-1:0] tbl_sine1x;
    logic [COEF_W-1:0] tbl_cos2x;
    logic              osc_wrap;
    logic              osc_ready;
    logic [COEF_W-1:0] init1;
    logic [COEF_W-1:0] init2;
    logic              osc_load;
    logic              busy;
    logic              timeout;

    dds_reload_ctrl #(
        .ADDR_W (ADDR_W),
        .COEF_W (COEF_W),
        .TBL_LAT(TBL_LAT),
        .SYNC_TO(SYNC_TO)
    ) dut (
        .Fg_clk    (Fg_clk),
        .Resetn    (Resetn),
        .FreqChng  (FreqChng),
        .ModeChng  (ModeChng),
        .address   (address),
        .tbl_addr  (tbl_addr),
        .tbl_sine1x(tbl_sine1x),
        .tbl_cos2x (tbl_cos2x),
        .osc_wrap  (osc_wrap),
        .osc_ready (osc_ready),
        .init1     (init1),
        .init2     (init2),
        .osc_load  (osc_load),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial Fg_clk = 1'b0;
    always #5 Fg_clk = ~Fg_clk;

    int n_vec = 0;
    int n_err = 0;

    // Coefficient table contents (address 100 carries the documented pair).
    function automatic logic [31:0] f1(input logic [10:0] a);
        if (a == 11'd100) return 32'h1234_5678;
        return 32'h5A00_0000 ^ ({21'd0, a} * 32'd65539);
    endfunction

    function automatic logic [31:0] f2(input logic [10:0] a);
        if (a == 11'd100) return 32'h0ABC_DEF0;
        return 32'hC300_0000 ^ (({21'd0, a} * 32'd7) + 32'd1);
    endfunction

    // Table with one cycle of internal latency behind the registered address.
    always @(posedge Fg_clk) begin
        tbl_sine1x <= f1(tbl_addr);
        tbl_cos2x  <= f2(tbl_addr);
    end

    // ---------------- reference model ----------------
    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_SYNC = 2, PH_LOAD = 3, PH_ACK = 4;
    int          ph;
    int          left;
    logic [10:0] m_tbl_addr;
    logic [31:0] m_init1, m_init2;
    bit          m_to;
    bit          m_pend;
    logic [10:0] m_pend_addr;

    task automatic model_reset();
        ph = PH_IDLE; left = 0; m_tbl_addr = '0; m_init1 = '0; m_init2 = '0;
        m_to = 0; m_pend = 0; m_pend_addr = '0;
    endtask

    task automatic start_fetch(input logic [10:0] a);
        m_tbl_addr = a; ph = PH_FETCH; left = TBL_LAT;
    endtask

    task automatic remember(input logic [10:0] a);
        m_pend = 1; m_pend_addr = a;
    endtask

    task automatic model_step(input bit ev, input logic [10:0] a, input bit w, input bit r);
        case (ph)
            PH_IDLE: if (ev) start_fetch(a);
            PH_FETCH: begin
                if (ev) remember(a);
                left--;
                if (left == 0) begin
                    m_init1 = f1(m_tbl_addr); m_init2 = f2(m_tbl_addr);
                    ph = PH_SYNC; left = SYNC_TO;
                end
            end
            PH_SYNC: begin
                if (ev) remember(a);
                left--;
                if (w) ph = PH_LOAD;
                else if (left == 0) begin m_to = 1; ph = PH_LOAD; end
            end
            PH_LOAD: begin
                if (ev) remember(a);
                ph = PH_ACK; left = SYNC_TO;
            end
            default: begin
                left--;
                if (r || left == 0) begin
                    if (!r) m_to = 1;
                    if (ev) start_fetch(a);
                    else if (m_pend) start_fetch(m_pend_addr);
                    else ph = PH_IDLE;
                    m_pend = 0;
                end else if (ev) remember(a);
            end
        endcase
    endtask

    task automatic check_model();
        bit e_load, e_busy;
        e_load = (ph == PH_LOAD);
        e_busy = (ph != PH_IDLE);
        n_vec++;
        if (tbl_addr !== m_tbl_addr || init1 !== m_init1 || init2 !== m_init2 ||
            osc_load !== e_load || busy !== e_busy || timeout !== m_to) begin
            n_err++;
            $display("FAIL model t=%0t: got addr=%0d i1=%h i2=%h load=%b busy=%b to=%b, expected addr=%0d i1=%h i2=%h load=%b busy=%b to=%b",
                     $time, tbl_addr, init1, init2, osc_load, busy, timeout,
                     m_tbl_addr, m_init1, m_init2, e_load, e_busy, m_to);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic cycle(input bit f, input bit m, input logic [10:0] a, input bit w, input bit r);
        FreqChng = f; ModeChng = m; address = a; osc_wrap = w; osc_ready = r;
        model_step(f | m, a, w, r);
        @(negedge Fg_clk);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 11'd0, 0, 0);
    endtask

    task automatic do_reset();
        FreqChng = 0; ModeChng = 0; address = '0; osc_wrap = 0; osc_ready = 0;
        Resetn = 0;
        model_reset();
        repeat (3) @(negedge Fg_clk);
        Resetn = 1;
    endtask

    // ---------------- load monitor ----------------
    bit          prev_load = 0;
    int          load_count = 0;
    logic [10:0] load_addrs[$];
    bit          seen_bad = 0;

    always @(negedge Fg_clk) begin
        if (osc_load === 1'b1) begin
            load_count++;
            load_addrs.push_back(tbl_addr);
            n_vec++;
            if (prev_load) begin
                n_err++;
                $display("FAIL load_consecutive t=%0t: got two strobes in a row, expected one", $time);
            end
        end
        prev_load = (osc_load === 1'b1);
        if (tbl_addr == 11'd6 || tbl_addr == 11'd7) seen_bad = 1;
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          f;
        bit          m;
        logic [10:0] a;
        bit          w;
        bit          r;
        logic [10:0] e_addr;
        logic [31:0] e_i1;
        logic [31:0] e_i2;
        bit          e_load;
        bit          e_busy;
        bit          e_to;
    } vec_t;

    function automatic vec_t mkv(input bit f, input bit w, input bit r, input logic [10:0] a,
                                 input logic [10:0] ea, input logic [31:0] i1, input logic [31:0] i2,
                                 input bit el, input bit eb);
        vec_t v;
        v.f = f; v.m = 0; v.a = a; v.w = w; v.r = r;
        v.e_addr = ea; v.e_i1 = i1; v.e_i2 = i2; v.e_load = el; v.e_busy = eb; v.e_to = 0;
        return v;
    endfunction

    initial begin
        vec_t        vecs[16];
        int          base;
        logic [10:0] la;

        FreqChng = 0; ModeChng = 0; address = '0; osc_wrap = 0; osc_ready = 0;
        Resetn = 0;
        model_reset();
        repeat (3) @(negedge Fg_clk);
        chk("reset_tbl_addr", {21'd0, tbl_addr}, 32'd0);
        chk("reset_init1", init1, 32'd0);
        chk("reset_init2", init2, 32'd0);
        chk("reset_flags", {29'd0, osc_load, busy, timeout}, 32'd0);
        Resetn = 1;

        // Basic reload: address 100, wrap ten cycles into the sequence, ready one cycle after load.
        vecs[0] = mkv(1, 0, 0, 11'd100, 11'd100, 32'h0, 32'h0, 0, 1);
        vecs[1] = mkv(0, 0, 0, 11'd0,   11'd100, 32'h0, 32'h0, 0, 1);
        vecs[2] = mkv(0, 0, 0, 11'd0,   11'd100, 32'h1234_5678, 32'h0ABC_DEF0, 0, 1);
        for (int i = 3; i < 12; i++)
            vecs[i] = mkv(0, 0, 0, 11'd0, 11'd100, 32'h1234_5678, 32'h0ABC_DEF0, 0, 1);
        vecs[12] = mkv(0, 1, 0, 11'd0, 11'd100, 32'h1234_5678, 32'h0ABC_DEF0, 1, 1);
        vecs[13] = mkv(0, 0, 0, 11'd0, 11'd100, 32'h1234_5678, 32'h0ABC_DEF0, 0, 1);
        vecs[14] = mkv(0, 0, 1, 11'd0, 11'd100, 32'h1234_5678, 32'h0ABC_DEF0, 0, 0);
        vecs[15] = mkv(0, 0, 0, 11'd0, 11'd100, 32'h1234_5678, 32'h0ABC_DEF0, 0, 0);

        base = load_count;
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].f, vecs[i].m, vecs[i].a, vecs[i].w, vecs[i].r);
            n_vec++;
            if (tbl_addr !== vecs[i].e_addr || init1 !== vecs[i].e_i1 || init2 !== vecs[i].e_i2 ||
                osc_load !== vecs[i].e_load || busy !== vecs[i].e_busy || timeout !== vecs[i].e_to) begin
                n_err++;
                $display("FAIL vec%0d: got addr=%0d i1=%h i2=%h load=%b busy=%b to=%b, expected addr=%0d i1=%h i2=%h load=%b busy=%b to=%b",
                         i, tbl_addr, init1, init2, osc_load, busy, timeout,
                         vecs[i].e_addr, vecs[i].e_i1, vecs[i].e_i2, vecs[i].e_load, vecs[i].e_busy, vecs[i].e_to);
            end
        end
        chk("basic_load_count", load_count - base, 32'd1);

        // Burst coalescing: 5 then 6,7,8 during fetch/sync -> loads for 5 and 8 only.
        seen_bad = 0;
        base = load_count;
        cycle(1, 0, 11'd5, 0, 0);
        cycle(1, 0, 11'd6, 0, 0);
        cycle(1, 0, 11'd7, 0, 0);
        cycle(1, 0, 11'd8, 0, 0);
        idle(3);
        cycle(0, 0, 11'd0, 1, 0);
        idle(1);
        cycle(0, 0, 11'd0, 0, 1);
        chk("burst_refetch_addr", {21'd0, tbl_addr}, 32'd8);
        idle(2);
        cycle(0, 0, 11'd0, 1, 0);
        idle(1);
        cycle(0, 0, 11'd0, 0, 1);
        idle(3);
        chk("burst_load_count", load_count - base, 32'd2);
        la = load_addrs[load_addrs.size() - 2];
        chk("burst_first_addr", {21'd0, la}, 32'd5);
        la = load_addrs[load_addrs.size() - 1];
        chk("burst_second_addr", {21'd0, la}, 32'd8);
        chk("burst_no_6_or_7", {31'd0, seen_bad}, 32'd0);
        chk("burst_idle", {31'd0, busy}, 32'd0);

        // Sync timeout: no wrap, load forced SYNC_TO cycles after SYNC entry.
        do_reset();
        cycle(1, 0, 11'd300, 0, 0);
        idle(2);
        idle(SYNC_TO - 1);
        chk("sync_to_no_early_load", {31'd0, osc_load}, 32'd0);
        chk("sync_to_not_yet", {31'd0, timeout}, 32'd0);
        idle(1);
        chk("sync_to_load", {31'd0, osc_load}, 32'd1);
        chk("sync_to_flag", {31'd0, timeout}, 32'd1);
        idle(1);
        cycle(0, 0, 11'd0, 0, 1);
        cycle(1, 0, 11'd301, 0, 0);
        idle(2);
        cycle(0, 0, 11'd0, 1, 0);
        idle(1);
        cycle(0, 0, 11'd0, 0, 1);
        idle(2);
        chk("sync_to_sticky", {31'd0, timeout}, 32'd1);

        // Ack timeout: ready never comes; back to IDLE after SYNC_TO cycles in ACK.
        do_reset();
        base = load_count;
        cycle(1, 0, 11'd400, 0, 0);
        idle(2);
        cycle(0, 0, 11'd0, 1, 0);
        idle(1);
        idle(SYNC_TO - 1);
        chk("ack_to_still_busy", {31'd0, busy}, 32'd1);
        idle(1);
        chk("ack_to_idle", {31'd0, busy}, 32'd0);
        chk("ack_to_flag", {31'd0, timeout}, 32'd1);
        idle(5);
        chk("ack_to_one_load", load_count - base, 32'd1);

        // Event in the ACK exit cycle while 30 is pending: 42 is fetched directly.
        do_reset();
        base = load_count;
        cycle(1, 0, 11'd20, 0, 0);
        cycle(1, 0, 11'd30, 0, 0);
        idle(1);
        cycle(0, 0, 11'd0, 1, 0);
        idle(1);
        cycle(0, 1, 11'd42, 0, 1);
        chk("ackev_addr", {21'd0, tbl_addr}, 32'd42);
        idle(2);
        cycle(0, 0, 11'd0, 1, 0);
        idle(1);
        cycle(0, 0, 11'd0, 0, 1);
        idle(3);
        chk("ackev_idle", {31'd0, busy}, 32'd0);
        chk("ackev_load_count", load_count - base, 32'd2);
        la = load_addrs[load_addrs.size() - 1];
        chk("ackev_last_addr", {21'd0, la}, 32'd42);

        // Reset mid-SYNC with a pending event: everything clears at once.
        cycle(1, 0, 11'd50, 0, 0);
        cycle(1, 0, 11'd60, 0, 0);
        idle(3);
        #2 Resetn = 0;
        #1;
        chk("rst_async_addr", {21'd0, tbl_addr}, 32'd0);
        chk("rst_async_init1", init1, 32'd0);
        chk("rst_async_init2", init2, 32'd0);
        chk("rst_async_flags", {29'd0, osc_load, busy, timeout}, 32'd0);
        #97;
        Resetn = 1;
        model_reset();
        base = load_count;
        idle(20);
        chk("rst_no_load", load_count - base, 32'd0);
        chk("rst_idle", {31'd0, busy}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  11'($urandom_range(0, 2047)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
